// File: rtl/bcd_display_scan_pkg.sv
// Shared definitions for the multiplexed BCD display scanner: scan state
// encoding, the blank code understood by the downstream decoder, and clog2.
package bcd_display_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam logic [3:0] BCD_BLANK = 4'b1111;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_scan_prescaler.sv
// Free-running 0..PRESCALE-1 slot counter. Strobes are registered and flag
// the current cycle as the last blank cycle, the last slot cycle, or the one before.
module bcd_scan_prescaler
    import bcd_display_scan_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_end,
    output logic slot_end,
    output logic slot_near_end
);

    localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_NEAR   = CW'(PRESCALE - 2);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic          HAS_BLANK  = (BLANK_CYCLES != 0);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          blank_end_r;
    logic          slot_end_r;
    logic          slot_near_end_r;

    // Next count with wrap at the end of the slot.
    always_comb begin
        cnt_s = cnt_r;
        if (cnt_r == CNT_LAST) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CW'(1);
        end
    end

    // Counter and strobes, decoded from the next count so they line up with cnt_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r           <= '0;
            blank_end_r     <= (BLANK_CYCLES == 1);
            slot_end_r      <= 1'b0;
            slot_near_end_r <= (PRESCALE == 2);
        end else begin
            cnt_r           <= cnt_s;
            blank_end_r     <= HAS_BLANK && (cnt_s == BLANK_LAST);
            slot_end_r      <= (cnt_s == CNT_LAST);
            slot_near_end_r <= (cnt_s == CNT_NEAR);
        end
    end

    assign blank_end     = blank_end_r;
    assign slot_end      = slot_end_r;
    assign slot_near_end = slot_near_end_r;

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed scan controller feeding a single-digit BCD-to-7-segment
// decoder: digit mux, ghost blanking, leading-zero suppression, tear-free load.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int PRESCALE         = 50000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic                    bcd_a,
    output logic                    bcd_b,
    output logic                    bcd_c,
    output logic                    bcd_d,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    load_ack,
    output logic                    frame_done
);

    localparam int IW = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = {NUM_DIGITS{(ANODE_ACTIVE_LOW != 0)}};
    localparam scan_state_e           SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    logic blank_end_s;
    logic slot_end_s;
    logic slot_near_end_s;

    scan_state_e           state_r,   state_s;
    logic [IW-1:0]         idx_r,     idx_s;
    logic [DW-1:0]         active_r,  active_s;
    logic [DW-1:0]         pending_r, pending_s;
    logic                  pending_flag_r, pending_flag_s;
    logic                  load_ack_r,   load_ack_s;
    logic                  frame_done_r, frame_done_s;
    logic [NUM_DIGITS-1:0] anode_r,   anode_s;
    logic [3:0]            bcd_r,     bcd_s;
    logic [NUM_DIGITS-1:0] suppress_s;
    logic                  zero_run_s;
    logic [3:0]            digit_s;
    logic                  show_s;

    bcd_scan_prescaler #(
        .PRESCALE    (PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_prescaler (
        .clk          (clk),
        .rst_n        (rst_n),
        .blank_end    (blank_end_s),
        .slot_end     (slot_end_s),
        .slot_near_end(slot_near_end_s)
    );

    // Load handshake: the active word only changes on the frame boundary cycle.
    always_comb begin
        active_s       = active_r;
        pending_s      = pending_r;
        pending_flag_s = pending_flag_r;
        load_ack_s     = 1'b0;
        if (frame_done_r) begin
            if (load) begin
                active_s       = digits_in;
                pending_flag_s = 1'b0;
                load_ack_s     = 1'b1;
            end else if (pending_flag_r) begin
                active_s       = pending_r;
                pending_flag_s = 1'b0;
                load_ack_s     = 1'b1;
            end else begin
                load_ack_s     = 1'b0;
            end
        end else if (load) begin
            pending_s      = digits_in;
            pending_flag_s = 1'b1;
        end else begin
            pending_s      = pending_r;
        end
    end

    // Slot sequencing; frame_done looks one cycle ahead so it lands on the last cycle.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        if (slot_end_s) begin
            state_s = SLOT_START;
            if (idx_r == IDX_LAST) begin
                idx_s = '0;
            end else begin
                idx_s = idx_r + IW'(1);
            end
        end else if (blank_end_s) begin
            state_s = SHOW;
        end else begin
            state_s = state_r;
        end
        frame_done_s = slot_near_end_s && (idx_r == IDX_LAST);
    end

    // Digit selection; all-ones digits (including the reset word) light no anode.
    always_comb begin
        suppress_s = '0;
        zero_run_s = lz_en;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s    = zero_run_s && (active_s[4*k +: 4] == 4'h0);
            suppress_s[k] = zero_run_s && (k != 0);
        end
        digit_s = active_s[4*int'(idx_s) +: 4];
        show_s  = (state_s == SHOW) && !suppress_s[idx_s] && (digit_s != BCD_BLANK);
        if (show_s) begin
            anode_s = ANODE_OFF ^ (NUM_DIGITS'(1) << idx_s);
            bcd_s   = digit_s;
        end else begin
            anode_s = ANODE_OFF;
            bcd_s   = BCD_BLANK;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= BLANK;
            idx_r          <= '0;
            active_r       <= {NUM_DIGITS{BCD_BLANK}};
            pending_r      <= {NUM_DIGITS{BCD_BLANK}};
            pending_flag_r <= 1'b0;
            load_ack_r     <= 1'b0;
            frame_done_r   <= 1'b0;
            anode_r        <= ANODE_OFF;
            bcd_r          <= BCD_BLANK;
        end else begin
            state_r        <= state_s;
            idx_r          <= idx_s;
            active_r       <= active_s;
            pending_r      <= pending_s;
            pending_flag_r <= pending_flag_s;
            load_ack_r     <= load_ack_s;
            frame_done_r   <= frame_done_s;
            anode_r        <= anode_s;
            bcd_r          <= bcd_s;
        end
    end

    assign bcd_a      = bcd_r[3];
    assign bcd_b      = bcd_r[2];
    assign bcd_c      = bcd_r[1];
    assign bcd_d      = bcd_r[0];
    assign anode      = anode_r;
    assign load_ack   = load_ack_r;
    assign frame_done = frame_done_r;

endmodule
